// File: rtl/link_rx_buffer_pkg.sv
// Shared node-level definitions for the link receive buffers: instruction width,
// default FIFO geometry and the input-port identifiers of a node.
package link_rx_buffer_pkg;

    localparam int INSTR_W      = 32;
    localparam int RX_DEPTH     = 4;
    localparam int RX_ADDR_W    = 2;
    localparam int RX_DROP_CNT_W = 8;

    typedef enum logic [1:0] {
        PORT_LEFT  = 2'd0,
        PORT_RIGHT = 2'd1,
        PORT_SELF  = 2'd2
    } port_sel_e;

endpackage

// File: rtl/link_fifo_mem.sv
// Storage array for the receive FIFO: one synchronous write port and one
// asynchronous read port so the head word is visible the cycle after it is written.
module link_fifo_mem
    import link_rx_buffer_pkg::*;
#(
    parameter int DATA_W = INSTR_W,
    parameter int DEPTH  = RX_DEPTH,
    parameter int ADDR_W = RX_ADDR_W
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Contents are not reset; validity is tracked by the occupancy count in the parent
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/link_rx_buffer.sv
// Elastic input stage between a neighbour's link output and a receiver queue port:
// captures strobed words in a small FIFO, shows the oldest one, and reports dropped pushes.
module link_rx_buffer
    import link_rx_buffer_pkg::*;
#(
    parameter int DATA_W = INSTR_W,
    parameter int DEPTH  = RX_DEPTH,
    parameter int ADDR_W = RX_ADDR_W,
    parameter int CNT_W  = RX_DROP_CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_cs,
    output logic [DATA_W-1:0] out_sig,
    output logic              out_check,
    input  logic              out_accept,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              overflow,
    output logic [CNT_W-1:0]  drop_count,
    input  logic              clr_ovf
);

    localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
    localparam logic [CNT_W-1:0]  DROP_ONE = CNT_W'(1);

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              full_q, full_d;
    logic              check_q, check_d;
    logic              ovf_q, ovf_d;
    logic [CNT_W-1:0]  drop_q, drop_d;

    logic              push_s, pop_s, drop_s;
    logic [DATA_W-1:0] head_s;

    // A pop frees a slot in the same cycle, so a full FIFO can still take a push
    assign pop_s  = check_q && out_accept;
    assign push_s = in_cs && (!full_q || pop_s);
    assign drop_s = in_cs && full_q && !pop_s;

    link_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk_i   (clk),
        .we_i    (push_s),
        .waddr_i (wr_ptr_q),
        .wdata_i (in_data),
        .raddr_i (rd_ptr_q),
        .rdata_o (head_s)
    );

    // Next-state for pointers, occupancy and the overflow bookkeeping
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        drop_d   = drop_q;

        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        // Clear first so a drop in the same cycle restarts the count at one
        if (clr_ovf) begin
            ovf_d  = 1'b0;
            drop_d = '0;
        end else begin
            ovf_d  = ovf_q;
            drop_d = drop_q;
        end

        if (drop_s) begin
            ovf_d = 1'b1;
            if (drop_d != {CNT_W{1'b1}}) begin
                drop_d = drop_d + DROP_ONE;
            end else begin
                drop_d = drop_d;
            end
        end else begin
            ovf_d = ovf_d;
        end

        full_d  = (count_d == FULL_CNT);
        check_d = (count_d != '0);
    end

    // State register; reset wins over every other input in the same cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            check_q  <= 1'b0;
            ovf_q    <= 1'b0;
            drop_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            check_q  <= check_d;
            ovf_q    <= ovf_d;
            drop_q   <= drop_d;
        end
    end

    assign out_sig    = check_q ? head_s : '0;
    assign out_check  = check_q;
    assign count      = count_q;
    assign full       = full_q;
    assign overflow   = ovf_q;
    assign drop_count = drop_q;

endmodule

// File: tb/tb_link_rx_buffer.sv
// Self-checking bench for link_rx_buffer: directed table, corner-case sequences and
// random traffic compared against a queue-based reference model.
module tb_link_rx_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] in_data;
    logic        in_cs;
    logic [31:0] out_sig;
    logic        out_check;
    logic        out_accept;
    logic [2:0]  count;
    logic        full;
    logic        overflow;
    logic [7:0]  drop_count;
    logic        clr_ovf;

    int checks = 0;
    int errors = 0;

    logic [31:0] mq [$];
    logic        m_ovf;
    int          m_drop;
    logic [31:0] popped [$];

    typedef struct {
        logic        rst;
        logic        cs;
        logic [31:0] data;
        logic        acc;
        logic        clr;
        int          e_count;
        logic        e_check;
        logic [31:0] e_sig;
        logic        e_full;
        logic        e_ovf;
        int          e_drop;
    } vec_t;

    vec_t vecs [12];

    link_rx_buffer dut (
        .clk        (clk),
        .reset      (reset),
        .in_data    (in_data),
        .in_cs      (in_cs),
        .out_sig    (out_sig),
        .out_check  (out_check),
        .out_accept (out_accept),
        .count      (count),
        .full       (full),
        .overflow   (overflow),
        .drop_count (drop_count),
        .clr_ovf    (clr_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input logic rst, input logic cs, input logic [31:0] d,
                              input logic acc, input logic clr);
        bit pop, push, drop;
        if (rst) begin
            mq.delete();
            m_ovf  = 1'b0;
            m_drop = 0;
        end else begin
            pop  = acc && (mq.size() > 0);
            push = cs && ((mq.size() < 4) || pop);
            drop = cs && !push;
            if (pop) void'(mq.pop_front());
            if (push) mq.push_back(d);
            if (clr) begin
                m_ovf  = 1'b0;
                m_drop = 0;
            end
            if (drop) begin
                m_ovf  = 1'b1;
                m_drop = (m_drop < 255) ? m_drop + 1 : 255;
            end
        end
    endtask

    task automatic compare_model(input string tag);
        chk({tag, ".count"}, 32'(count), 32'(mq.size()));
        chk({tag, ".full"}, 32'(full), 32'(mq.size() == 4));
        chk({tag, ".check"}, 32'(out_check), 32'(mq.size() != 0));
        chk({tag, ".sig"}, out_sig, (mq.size() != 0) ? mq[0] : 32'h0);
        chk({tag, ".ovf"}, 32'(overflow), 32'(m_ovf));
        chk({tag, ".drop"}, 32'(drop_count), 32'(m_drop));
    endtask

    // One clock: drive inputs, record any word consumed, advance model, compare
    task automatic cycle(input logic rst, input logic cs, input logic [31:0] d,
                         input logic acc, input logic clr, input string tag);
        reset      = rst;
        in_cs      = cs;
        in_data    = d;
        out_accept = acc;
        clr_ovf    = clr;
        #1;
        if (!rst && out_check && acc) popped.push_back(out_sig);
        @(posedge clk);
        #1;
        model_step(rst, cs, d, acc, clr);
        compare_model(tag);
    endtask

    initial begin
        reset = 1'b1; in_cs = 1'b0; in_data = 32'h0; out_accept = 1'b0; clr_ovf = 1'b0;
        m_ovf = 1'b0; m_drop = 0;
        @(posedge clk); #1;

        //                rst   cs    data           acc   clr   cnt chk  sig            full  ovf  drop
        vecs[0]  = '{1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 0, 1'b0, 32'h0,         1'b0, 1'b0, 0};
        vecs[1]  = '{1'b0, 1'b1, 32'hA5A5_0001, 1'b0, 1'b0, 1, 1'b1, 32'hA5A5_0001, 1'b0, 1'b0, 0};
        vecs[2]  = '{1'b0, 1'b1, 32'h0000_0002, 1'b0, 1'b0, 2, 1'b1, 32'hA5A5_0001, 1'b0, 1'b0, 0};
        vecs[3]  = '{1'b0, 1'b1, 32'h0000_0003, 1'b0, 1'b0, 3, 1'b1, 32'hA5A5_0001, 1'b0, 1'b0, 0};
        vecs[4]  = '{1'b0, 1'b1, 32'h0000_0004, 1'b0, 1'b0, 4, 1'b1, 32'hA5A5_0001, 1'b1, 1'b0, 0};
        vecs[5]  = '{1'b0, 1'b1, 32'h0000_0005, 1'b0, 1'b0, 4, 1'b1, 32'hA5A5_0001, 1'b1, 1'b1, 1};
        vecs[6]  = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 3, 1'b1, 32'h0000_0002, 1'b0, 1'b1, 1};
        vecs[7]  = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 2, 1'b1, 32'h0000_0003, 1'b0, 1'b1, 1};
        vecs[8]  = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 1, 1'b1, 32'h0000_0004, 1'b0, 1'b1, 1};
        vecs[9]  = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 0, 1'b0, 32'h0,         1'b0, 1'b1, 1};
        vecs[10] = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 0, 1'b0, 32'h0,         1'b0, 1'b1, 1};
        vecs[11] = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 0, 1'b0, 32'h0,         1'b0, 1'b0, 0};

        for (int i = 0; i < 12; i++) begin
            cycle(vecs[i].rst, vecs[i].cs, vecs[i].data, vecs[i].acc, vecs[i].clr, $sformatf("vec%0d", i));
            chk($sformatf("tbl%0d.count", i), 32'(count), 32'(vecs[i].e_count));
            chk($sformatf("tbl%0d.check", i), 32'(out_check), 32'(vecs[i].e_check));
            chk($sformatf("tbl%0d.sig", i), out_sig, vecs[i].e_sig);
            chk($sformatf("tbl%0d.full", i), 32'(full), 32'(vecs[i].e_full));
            chk($sformatf("tbl%0d.ovf", i), 32'(overflow), 32'(vecs[i].e_ovf));
            chk($sformatf("tbl%0d.drop", i), 32'(drop_count), 32'(vecs[i].e_drop));
        end

        // Full FIFO with simultaneous push and pop: no drop, new word ends up last
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 32'h10 + 32'(i), 1'b0, 1'b0, "fill3");
        popped.delete();
        cycle(1'b0, 1'b1, 32'h99, 1'b1, 1'b0, "pushpop");
        chk("pp.count", 32'(count), 32'd4);
        chk("pp.ovf", 32'(overflow), 32'd0);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, "drain3");
        chk("pp.npop", 32'(popped.size()), 32'd5);
        if (popped.size() == 5) chk("pp.last", popped[4], 32'h99);

        // Drop counter saturation, then clear
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 32'h20 + 32'(i), 1'b0, 1'b0, "fill4");
        for (int i = 0; i < 300; i++) cycle(1'b0, 1'b1, 32'hDEAD_0000 + 32'(i), 1'b0, 1'b0, "sat");
        chk("sat.drop", 32'(drop_count), 32'd255);
        chk("sat.ovf", 32'(overflow), 32'd1);
        chk("sat.head", out_sig, 32'h20);
        cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, "clr");
        chk("clr.drop", 32'(drop_count), 32'd0);
        chk("clr.ovf", 32'(overflow), 32'd0);
        // Clear and drop together: drop wins
        cycle(1'b0, 1'b1, 32'h77, 1'b0, 1'b1, "clrdrop");
        chk("clrdrop.drop", 32'(drop_count), 32'd1);
        chk("clrdrop.ovf", 32'(overflow), 32'd1);

        // Continuous stream through pointer wrap
        cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, "rst5");
        popped.delete();
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 1'b1, 32'h100 + 32'(i), 1'b1, 1'b0, "wrap");
            chk("wrap.cnt_le1", 32'(count <= 3'd1), 32'd1);
        end
        cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, "wrapend");
        chk("wrap.npop", 32'(popped.size()), 32'd10);
        for (int i = 0; i < 10 && i < popped.size(); i++)
            chk($sformatf("wrap.ord%0d", i), popped[i], 32'h100 + 32'(i));

        // Reset mid-burst with a push pending
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 32'h300 + 32'(i), 1'b0, 1'b0, "fill6");
        cycle(1'b1, 1'b1, 32'h3FF, 1'b0, 1'b0, "rst6");
        chk("rst6.count", 32'(count), 32'd0);
        chk("rst6.check", 32'(out_check), 32'd0);
        cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, "post6");
        chk("post6.count", 32'(count), 32'd0);

        // Random traffic against the model
        for (int i = 0; i < 600; i++) begin
            cycle(($urandom_range(0, 99) == 0), ($urandom_range(0, 99) < 60), $urandom(),
                  ($urandom_range(0, 99) < 45), ($urandom_range(0, 99) < 3), "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
